// File: rtl/conv_controller_fsm_gen_if.sv
// Operand handshake, MAC control, partial-sum memory and output-pixel bundle
// driven by conv_controller_fsm_gen.
interface conv_controller_fsm_gen_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              a_valid;
  logic              b_valid;
  logic              a_ready;
  logic              b_ready;
  logic              write_a;
  logic              write_b;
  logic              mac_valid;
  logic              mac_accumulate_internal;
  logic              mac_accumulate_with_0;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_write_addr;
  logic              output_valid;
  logic [31:0]       output_x;
  logic [31:0]       output_y;
  logic [31:0]       output_ch;

  modport master (
    input  a_valid, b_valid,
    output a_ready, b_ready, write_a, write_b,
    output mac_valid, mac_accumulate_internal, mac_accumulate_with_0,
    output mem_re, mem_read_addr, mem_we, mem_write_addr,
    output output_valid, output_x, output_y, output_ch
  );

  modport slave (
    output a_valid, b_valid,
    input  a_ready, b_ready, write_a, write_b,
    input  mac_valid, mac_accumulate_internal, mac_accumulate_with_0,
    input  mem_re, mem_read_addr, mem_we, mem_write_addr,
    input  output_valid, output_x, output_y, output_ch
  );
endinterface

// File: rtl/conv_controller_fsm_gen.sv
// Stalling x/y/ch_in/ch_out/k_v/k_h loop sequencer with MAC-depth retimed write-back.
// Optional macro CONV_CTRL_PERF_CNT_EN adds the stall_cycles counter port.
module conv_controller_fsm_gen #(
  parameter int unsigned LOG2_OF_MEM_HEIGHT = 20,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  parameter int unsigned MAC_PIPE_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        arst_n_in,
  input  logic        start,
  output logic        running,
`ifdef CONV_CTRL_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  conv_controller_fsm_gen_if.master bus
);
  localparam int unsigned CW         = 32;
  localparam int unsigned AW         = LOG2_OF_MEM_HEIGHT;
  localparam int unsigned DW         = $clog2(MAC_PIPE_DEPTH + 1) + 1;
  localparam int unsigned LAST_STAGE = MAC_PIPE_DEPTH - 1;
  localparam logic [CW-1:0] X_LAST  = CW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CW-1:0] CI_LAST = CW'(INPUT_NB_CHANNELS - 1);
  localparam logic [CW-1:0] CO_LAST = CW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [CW-1:0] K_LAST  = CW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  typedef struct packed {
    logic          valid;
    logic          acc_int;
    logic          acc_w0;
    logic          we_tag;
    logic          out_tag;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [CW-1:0] co;
  } beat_t;

  state_t        state, state_n;
  logic [DW-1:0] drain_cnt;
  logic [CW-1:0] x_cnt, y_cnt, ci_cnt, co_cnt, kv_cnt, kh_cnt;
  logic          last_x, last_y, last_ci, last_co, last_kv, last_kh;
  logic          first_k, last_k, last_overall;
  logic          rdy_c, fire_c, running_c, mem_re_c;
  beat_t         beat_in_c;
  beat_t         pipe [MAC_PIPE_DEPTH];
  logic          mem_we_q, out_valid_q;
  logic [AW-1:0] mem_wa_q;
  logic [CW-1:0] out_x_q, out_y_q, out_ch_q;

  assign last_x       = (x_cnt == X_LAST);
  assign last_y       = (y_cnt == Y_LAST);
  assign last_ci      = (ci_cnt == CI_LAST);
  assign last_co      = (co_cnt == CO_LAST);
  assign last_kv      = (kv_cnt == K_LAST);
  assign last_kh      = (kh_cnt == K_LAST);
  assign first_k      = (kv_cnt == '0) && (kh_cnt == '0);
  assign last_k       = last_kv && last_kh;
  assign last_overall = last_x && last_y && last_ci && last_co && last_k;

  // State register
  always_ff @(posedge clk or negedge arst_n_in) begin : state_reg
    if (!arst_n_in) state <= IDLE;
    else            state <= state_n;
  end

  // Next-state logic
  always_comb begin : next_state
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (fire_c && last_overall) state_n = DRAIN;
      DRAIN:   if (drain_cnt == DW'(MAC_PIPE_DEPTH)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake, same-cycle memory read and the beat entering the MAC pipe
  always_comb begin : outputs
    rdy_c     = 1'b0;
    fire_c    = 1'b0;
    running_c = 1'b0;
    mem_re_c  = 1'b0;
    beat_in_c = '0;
    rdy_c     = (state == RUN);
    running_c = (state != IDLE);
    fire_c    = rdy_c && bus.a_valid && bus.b_valid;
    mem_re_c  = fire_c && first_k && (ci_cnt != '0);
    beat_in_c.valid   = fire_c;
    beat_in_c.acc_int = fire_c && !first_k;
    beat_in_c.acc_w0  = fire_c && first_k && (ci_cnt == '0);
    beat_in_c.we_tag  = fire_c && last_k;
    beat_in_c.out_tag = fire_c && last_k && last_ci;
    beat_in_c.x       = x_cnt;
    beat_in_c.y       = y_cnt;
    beat_in_c.co      = co_cnt;
  end

  // DRAIN lasts MAC_PIPE_DEPTH+1 cycles so the final tag reaches the outputs
  always_ff @(posedge clk or negedge arst_n_in) begin : drain_reg
    if (!arst_n_in)           drain_cnt <= '0;
    else if (state == DRAIN)  drain_cnt <= drain_cnt + DW'(1);
    else                      drain_cnt <= '0;
  end

  // Loop nest, innermost k_h; wraps back to all-zero after the last beat
  always_ff @(posedge clk or negedge arst_n_in) begin : loop_cnt
    if (!arst_n_in) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      ci_cnt <= '0;
      co_cnt <= '0;
      kv_cnt <= '0;
      kh_cnt <= '0;
    end else if (fire_c) begin
      kh_cnt <= last_kh ? '0 : kh_cnt + CW'(1);
      if (last_kh) begin
        kv_cnt <= last_kv ? '0 : kv_cnt + CW'(1);
        if (last_kv) begin
          co_cnt <= last_co ? '0 : co_cnt + CW'(1);
          if (last_co) begin
            ci_cnt <= last_ci ? '0 : ci_cnt + CW'(1);
            if (last_ci) begin
              y_cnt <= last_y ? '0 : y_cnt + CW'(1);
              if (last_y) x_cnt <= last_x ? '0 : x_cnt + CW'(1);
            end
          end
        end
      end
    end
  end

  // MAC pipe model: stage 0 is the mac_valid beat, last stage feeds write-back
  always_ff @(posedge clk or negedge arst_n_in) begin : pipe_regs
    if (!arst_n_in) begin
      for (int i = 0; i < int'(MAC_PIPE_DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= beat_in_c;
      for (int i = 1; i < int'(MAC_PIPE_DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin : out_regs
    if (!arst_n_in) begin
      mem_we_q    <= 1'b0;
      mem_wa_q    <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_ch_q    <= '0;
    end else begin
      mem_we_q    <= pipe[LAST_STAGE].we_tag;
      out_valid_q <= pipe[LAST_STAGE].out_tag;
      if (pipe[LAST_STAGE].we_tag) mem_wa_q <= AW'(pipe[LAST_STAGE].co);
      if (pipe[LAST_STAGE].out_tag) begin
        out_x_q  <= pipe[LAST_STAGE].x;
        out_y_q  <= pipe[LAST_STAGE].y;
        out_ch_q <= pipe[LAST_STAGE].co;
      end
    end
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  // Saturating count of RUN cycles without fire
  always_ff @(posedge clk or negedge arst_n_in) begin : perf_cnt
    if (!arst_n_in) begin
      stall_cycles <= '0;
    end else if (state == IDLE) begin
      if (start) stall_cycles <= '0;
    end else if (state == RUN && !fire_c && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign running                     = running_c;
  assign bus.a_ready                 = rdy_c;
  assign bus.b_ready                 = rdy_c;
  assign bus.write_a                 = fire_c;
  assign bus.write_b                 = fire_c;
  assign bus.mem_re                  = mem_re_c;
  assign bus.mem_read_addr           = AW'(co_cnt);
  assign bus.mac_valid               = pipe[0].valid;
  assign bus.mac_accumulate_internal = pipe[0].acc_int;
  assign bus.mac_accumulate_with_0   = pipe[0].acc_w0;
  assign bus.mem_we                  = mem_we_q;
  assign bus.mem_write_addr          = mem_wa_q;
  assign bus.output_valid            = out_valid_q;
  assign bus.output_x                = out_x_q;
  assign bus.output_y                = out_y_q;
  assign bus.output_ch               = out_ch_q;
endmodule

// File: tb/tb_conv_controller_fsm_gen.sv
// Directed bench for conv_controller_fsm_gen: a 2x2x2x2 K=2 depth-4 instance and a
// K=3 instance; define CONV_CTRL_PERF_CNT_EN for the stall counter checks.
module tb_conv_controller_fsm_gen;
  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_n_in, start, start3, running, running3;
`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles, stall3;
`endif

  conv_controller_fsm_gen_if #(.ADDR_W(AW)) bus ();
  conv_controller_fsm_gen_if #(.ADDR_W(AW)) bus3 ();

  conv_controller_fsm_gen #(
    .LOG2_OF_MEM_HEIGHT(AW), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(2), .MAC_PIPE_DEPTH(4)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
`ifdef CONV_CTRL_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .bus(bus.master)
  );

  conv_controller_fsm_gen #(
    .LOG2_OF_MEM_HEIGHT(AW), .FEATURE_MAP_WIDTH(1), .FEATURE_MAP_HEIGHT(1),
    .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .MAC_PIPE_DEPTH(2)
  ) dut3 (
    .clk(clk), .arst_n_in(arst_n_in), .start(start3), .running(running3),
`ifdef CONV_CTRL_PERF_CNT_EN
    .stall_cycles(stall3),
`endif
    .bus(bus3.master)
  );

  int errors = 0;
  int checks = 0;

  // Event recorder for the main instance
  int cyc = 0;
  int fire_cnt, first_fire, last_fire, last_out, fall_cyc;
  int re_cnt, re_stray, trail_err, w0_cnt, ai_cnt, stall_obs, we_cnt, out_cnt;
  logic prev_fire = 1'b0;
  logic prev_run  = 1'b0;
  int rd_addr [256];
  int we_addr [64];
  int ox [16];
  int oy [16];
  int oc [16];

  always @(negedge clk) begin
    #2;
    cyc++;
    if (bus.write_a) begin
      if (fire_cnt == 0) first_fire = cyc;
      last_fire = cyc;
      if (fire_cnt < 256) rd_addr[fire_cnt] = int'(bus.mem_read_addr);
      fire_cnt++;
      if (bus.mem_re) re_cnt++;
    end else if (bus.mem_re) begin
      re_stray++;
    end
    if (bus.mac_valid !== prev_fire) trail_err++;
    prev_fire = bus.write_a;
    if (bus.mac_valid && bus.mac_accumulate_with_0) w0_cnt++;
    if (bus.mac_valid && bus.mac_accumulate_internal) ai_cnt++;
    if (bus.a_ready && bus.b_ready && !bus.write_a) stall_obs++;
    if (bus.mem_we) begin
      if (we_cnt < 64) we_addr[we_cnt] = int'(bus.mem_write_addr);
      we_cnt++;
    end
    if (bus.output_valid) begin
      if (out_cnt < 16) begin
        ox[out_cnt] = int'(bus.output_x);
        oy[out_cnt] = int'(bus.output_y);
        oc[out_cnt] = int'(bus.output_ch);
      end
      out_cnt++;
      last_out = cyc;
    end
    if (prev_run && !running) fall_cyc = cyc;
    prev_run = running;
  end

  task automatic clear_mon();
    fire_cnt = 0; first_fire = -1; last_fire = -1; last_out = -1; fall_cyc = -1;
    re_cnt = 0; re_stray = 0; trail_err = 0; w0_cnt = 0; ai_cnt = 0;
    stall_obs = 0; we_cnt = 0; out_cnt = 0;
  endtask

  // Start a layer on the main instance and return once running has dropped
  task automatic run_layer(input bit toggle, input bit poke, output bit done);
    done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_valid = toggle ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (toggle) bus.a_valid = ~bus.a_valid;
      if (poke) start = (i % 3 == 1);
      #3;
      if (!running) begin
        done = 1'b1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    bus.a_valid = 1'b1;
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %0b expected 0", bus.a_ready); end
    checks++; if (bus.mac_valid !== 1'b0) begin errors++; $display("FAIL reset_mac_valid: got %0b expected 0", bus.mac_valid); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b expected 0", bus.mem_we); end
    checks++; if (bus.output_valid !== 1'b0) begin errors++; $display("FAIL reset_output_valid: got %0b expected 0", bus.output_valid); end
    checks++; if (bus.output_ch !== 32'd0) begin errors++; $display("FAIL reset_output_ch: got %0d expected 0", bus.output_ch); end
    @(negedge clk);
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_without_start: got %0b expected 0", running); end
    checks++; if (bus.write_a !== 1'b0) begin errors++; $display("FAIL idle_write_a: got %0b expected 0", bus.write_a); end
  endtask

  task automatic test_full_layer();
    bit done;
    int bad_out, bad_we, bad_rd;
    clear_mon();
    run_layer(1'b0, 1'b0, done);
    bad_out = 0; bad_we = 0; bad_rd = 0;
    for (int k = 0; k < 8; k++)
      if (ox[k] !== k / 4 || oy[k] !== (k / 2) % 2 || oc[k] !== k % 2) bad_out++;
    for (int k = 0; k < 16; k++) if (we_addr[k] !== k % 2) bad_we++;
    for (int k = 0; k < 64; k++) if (rd_addr[k] !== (k / 4) % 2) bad_rd++;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %0b expected 1", done); end
    checks++; if (fire_cnt !== 64) begin errors++; $display("FAIL full_fires: got %0d expected 64", fire_cnt); end
    checks++; if (last_fire - first_fire !== 63) begin errors++; $display("FAIL full_fire_span: got %0d expected 63", last_fire - first_fire); end
    checks++; if (trail_err !== 0) begin errors++; $display("FAIL full_mac_trail: got %0d expected 0", trail_err); end
    checks++; if (we_cnt !== 16) begin errors++; $display("FAIL full_mem_we_count: got %0d expected 16", we_cnt); end
    checks++; if (out_cnt !== 8) begin errors++; $display("FAIL full_output_count: got %0d expected 8", out_cnt); end
    checks++; if (last_out - last_fire !== 5) begin errors++; $display("FAIL full_last_out_lat: got %0d expected 5", last_out - last_fire); end
    checks++; if (fall_cyc - last_fire !== 6) begin errors++; $display("FAIL full_running_fall: got %0d expected 6", fall_cyc - last_fire); end
    checks++; if (re_cnt !== 8) begin errors++; $display("FAIL full_mem_re_count: got %0d expected 8", re_cnt); end
    checks++; if (re_stray !== 0) begin errors++; $display("FAIL full_mem_re_stray: got %0d expected 0", re_stray); end
    checks++; if (w0_cnt !== 8) begin errors++; $display("FAIL full_acc_with_0_count: got %0d expected 8", w0_cnt); end
    checks++; if (ai_cnt !== 48) begin errors++; $display("FAIL full_acc_internal_count: got %0d expected 48", ai_cnt); end
    checks++; if (bad_out !== 0) begin errors++; $display("FAIL full_output_coords: got %0d bad expected 0", bad_out); end
    checks++; if (bad_we !== 0) begin errors++; $display("FAIL full_write_addr: got %0d bad expected 0", bad_we); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL full_read_addr: got %0d bad expected 0", bad_rd); end
    checks++; if (stall_obs !== 0) begin errors++; $display("FAIL full_stalls: got %0d expected 0", stall_obs); end
  endtask

  task automatic test_stall();
    bit done;
    int bad_out, bad_rd;
    clear_mon();
    run_layer(1'b1, 1'b0, done);
    bad_out = 0; bad_rd = 0;
    for (int k = 0; k < 8; k++)
      if (ox[k] !== k / 4 || oy[k] !== (k / 2) % 2 || oc[k] !== k % 2) bad_out++;
    for (int k = 0; k < 64; k++) if (rd_addr[k] !== (k / 4) % 2) bad_rd++;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b expected 1", done); end
    checks++; if (fire_cnt !== 64) begin errors++; $display("FAIL stall_fires: got %0d expected 64", fire_cnt); end
    checks++; if (stall_obs !== 64) begin errors++; $display("FAIL stall_ready_no_fire: got %0d expected 64", stall_obs); end
    checks++; if (trail_err !== 0) begin errors++; $display("FAIL stall_mac_trail: got %0d expected 0", trail_err); end
    checks++; if (re_stray !== 0) begin errors++; $display("FAIL stall_mem_re_stray: got %0d expected 0", re_stray); end
    checks++; if (we_cnt !== 16) begin errors++; $display("FAIL stall_mem_we_count: got %0d expected 16", we_cnt); end
    checks++; if (out_cnt !== 8) begin errors++; $display("FAIL stall_output_count: got %0d expected 8", out_cnt); end
    checks++; if (bad_out !== 0) begin errors++; $display("FAIL stall_output_coords: got %0d bad expected 0", bad_out); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL stall_read_addr: got %0d bad expected 0", bad_rd); end
    checks++; if (last_out - last_fire !== 5) begin errors++; $display("FAIL stall_last_out_lat: got %0d expected 5", last_out - last_fire); end
    checks++; if (fall_cyc - last_fire !== 6) begin errors++; $display("FAIL stall_running_fall: got %0d expected 6", fall_cyc - last_fire); end
`ifdef CONV_CTRL_PERF_CNT_EN
    checks++; if (stall_cycles !== 32'd64) begin errors++; $display("FAIL perf_stall_cycles: got %0d expected 64", stall_cycles); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall_cycles !== 32'd64) begin errors++; $display("FAIL perf_hold_idle: got %0d expected 64", stall_cycles); end
`endif
  endtask

  task automatic test_first_beat();
    logic re3 [36];
    logic f3 [36];
    logic w0 [36];
    logic ai [36];
    logic mv [36];
    int ra3 [36];
    int nf, nmv;
    bit done;
    bus3.a_valid = 1'b1;
    bus3.b_valid = 1'b1;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 36; i++) begin
      #1;
      re3[i] = bus3.mem_re; ra3[i] = int'(bus3.mem_read_addr); f3[i] = bus3.write_a;
      @(negedge clk);
      #1;
      w0[i] = bus3.mac_accumulate_with_0; ai[i] = bus3.mac_accumulate_internal; mv[i] = bus3.mac_valid;
    end
    nf = 0; nmv = 0;
    for (int i = 0; i < 36; i++) begin
      if (f3[i] === 1'b1) nf++;
      if (mv[i] === 1'b1) nmv++;
    end
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #3;
      if (!running3) done = 1'b1;
    end
    checks++; if (nf !== 36) begin errors++; $display("FAIL k3_fires: got %0d expected 36", nf); end
    checks++; if (nmv !== 36) begin errors++; $display("FAIL k3_mac_valid: got %0d expected 36", nmv); end
    checks++; if (re3[0] !== 1'b0) begin errors++; $display("FAIL k3_beat0_mem_re: got %0b expected 0", re3[0]); end
    checks++; if (w0[0] !== 1'b1) begin errors++; $display("FAIL k3_beat0_with_0: got %0b expected 1", w0[0]); end
    checks++; if (ai[0] !== 1'b0) begin errors++; $display("FAIL k3_beat0_acc_int: got %0b expected 0", ai[0]); end
    checks++; if (ai[1] !== 1'b1) begin errors++; $display("FAIL k3_beat1_acc_int: got %0b expected 1", ai[1]); end
    checks++; if (w0[1] !== 1'b0) begin errors++; $display("FAIL k3_beat1_with_0: got %0b expected 0", w0[1]); end
    checks++; if (re3[9] !== 1'b0) begin errors++; $display("FAIL k3_beat9_mem_re: got %0b expected 0", re3[9]); end
    checks++; if (w0[9] !== 1'b1) begin errors++; $display("FAIL k3_beat9_with_0: got %0b expected 1", w0[9]); end
    checks++; if (re3[18] !== 1'b1) begin errors++; $display("FAIL k3_beat18_mem_re: got %0b expected 1", re3[18]); end
    checks++; if (ra3[18] !== 0) begin errors++; $display("FAIL k3_beat18_addr: got %0d expected 0", ra3[18]); end
    checks++; if (w0[18] !== 1'b0) begin errors++; $display("FAIL k3_beat18_with_0: got %0b expected 0", w0[18]); end
    checks++; if (ai[18] !== 1'b0) begin errors++; $display("FAIL k3_beat18_acc_int: got %0b expected 0", ai[18]); end
    checks++; if (re3[19] !== 1'b0) begin errors++; $display("FAIL k3_beat19_mem_re: got %0b expected 0", re3[19]); end
    checks++; if (re3[27] !== 1'b1) begin errors++; $display("FAIL k3_beat27_mem_re: got %0b expected 1", re3[27]); end
    checks++; if (ra3[27] !== 1) begin errors++; $display("FAIL k3_beat27_addr: got %0d expected 1", ra3[27]); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL k3_drain_done: got %0b expected 1", done); end
  endtask

  task automatic test_reset_mid_run();
    bit done;
    int bad_out, bad_rd;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (bus.mac_valid !== 1'b1) begin errors++; $display("FAIL midrun_active: got %0b expected 1", bus.mac_valid); end
    arst_n_in = 1'b0;
    #1;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %0b expected 0", running); end
    checks++; if (bus.mac_valid !== 1'b0) begin errors++; $display("FAIL rst_mac_valid: got %0b expected 0", bus.mac_valid); end
    checks++; if (bus.write_a !== 1'b0) begin errors++; $display("FAIL rst_write_a: got %0b expected 0", bus.write_a); end
    checks++; if (bus.output_ch !== 32'd0) begin errors++; $display("FAIL rst_output_ch: got %0d expected 0", bus.output_ch); end
    checks++; if (bus.mem_read_addr !== 20'd0) begin errors++; $display("FAIL rst_read_addr: got %0d expected 0", bus.mem_read_addr); end
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    clear_mon();
    run_layer(1'b0, 1'b0, done);
    bad_out = 0; bad_rd = 0;
    for (int k = 0; k < 8; k++)
      if (ox[k] !== k / 4 || oy[k] !== (k / 2) % 2 || oc[k] !== k % 2) bad_out++;
    for (int k = 0; k < 64; k++) if (rd_addr[k] !== (k / 4) % 2) bad_rd++;
    checks++; if (fire_cnt !== 64) begin errors++; $display("FAIL restart_fires: got %0d expected 64", fire_cnt); end
    checks++; if (bad_rd !== 0) begin errors++; $display("FAIL restart_read_addr: got %0d bad expected 0", bad_rd); end
    checks++; if (bad_out !== 0) begin errors++; $display("FAIL restart_output_coords: got %0d bad expected 0", bad_out); end
    checks++; if (out_cnt !== 8) begin errors++; $display("FAIL restart_output_count: got %0d expected 8", out_cnt); end
  endtask

  task automatic test_start_ignored();
    bit done;
    int prev_fall;
    clear_mon();
    run_layer(1'b0, 1'b1, done);
    checks++; if (fire_cnt !== 64) begin errors++; $display("FAIL poke_fires: got %0d expected 64", fire_cnt); end
    checks++; if (out_cnt !== 8) begin errors++; $display("FAIL poke_output_count: got %0d expected 8", out_cnt); end
    checks++; if (fall_cyc - last_fire !== 6) begin errors++; $display("FAIL poke_running_fall: got %0d expected 6", fall_cyc - last_fire); end
    prev_fall = fall_cyc;
    clear_mon();
    run_layer(1'b0, 1'b0, done);
    checks++; if (first_fire - prev_fall !== 2) begin errors++; $display("FAIL b2b_first_fire: got %0d expected 2", first_fire - prev_fall); end
    checks++; if (fire_cnt !== 64) begin errors++; $display("FAIL b2b_fires: got %0d expected 64", fire_cnt); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %0b expected 1", done); end
  endtask

  initial begin
    arst_n_in = 1'b0;
    start = 1'b0;
    start3 = 1'b0;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus3.a_valid = 1'b0;
    bus3.b_valid = 1'b0;
    clear_mon();
    test_reset();
    test_full_layer();
    test_stall();
    test_first_beat();
    test_reset_mid_run();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_controller_fsm_gen.md
Name: conv_controller_fsm_gen

Overview:
Parametrised next-generation loop controller for the convolution accelerator. It sequences the x/y/ch_in/ch_out/k_v/k_h loop nest over a full 2-D kernel with a real k_h loop, and stalls on the a/b valid-ready handshake instead of free-running. It drives the partial-sum memory and MAC datapath control, and retimes write-back and output marking through a configurable MAC pipeline depth. It sits between the operand streams and the datapath, replacing the fixed-depth controller.

Parameters:
LOG2_OF_MEM_HEIGHT, 20, partial-sum memory address width
FEATURE_MAP_WIDTH, 1024, x loop bound
FEATURE_MAP_HEIGHT, 1024, y loop bound
INPUT_NB_CHANNELS, 64, ch_in loop bound
OUTPUT_NB_CHANNELS, 64, ch_out loop bound
KERNEL_SIZE, 3, k_v and k_h loop bound (>=1)
MAC_PIPE_DEPTH, 4, cycles from mac_valid to accumulator result (>=1)

Ports:
clk  in  1  clock
arst_n_in  in  1  asynchronous active-low reset
start  in  1  pulse; begins a layer when idle
running  out  1  high in every state except IDLE
a_valid / b_valid  in  1  operand streams valid
a_ready / b_ready  out  1  operand streams ready
write_a / write_b  out  1  load operand registers (= fire)
mac_valid  out  1  MAC consumes loaded operands
mac_accumulate_internal  out  1  accumulate onto running sum
mac_accumulate_with_0  out  1  seed sum with 0 instead of memory
mem_re  out  1  partial-sum read
mem_read_addr  out  LOG2_OF_MEM_HEIGHT  = ch_out
mem_we  out  1  partial-sum write
mem_write_addr  out  LOG2_OF_MEM_HEIGHT  write address
output_valid  out  1  final output pixel valid
output_x / output_y / output_ch  out  32  coordinates of output pixel
stall_cycles  out  32  only when CONV_CTRL_PERF_CNT_EN defined

Behaviour:
- Reset arst_n_in, asynchronous, active-low; clock clk. Reset: state IDLE, all counters 0, every output 0.
- States IDLE, RUN, DRAIN. IDLE->RUN on start. RUN->DRAIN on fire with last_overall. DRAIN counts MAC_PIPE_DEPTH+1 cycles, then ->IDLE. start is ignored outside IDLE.
- a_ready = b_ready = (state==RUN). fire = RUN && a_valid && b_valid. write_a = write_b = fire. With only one valid high: no fire, no counter movement, and both readies stay high.
- Loop order from outer to inner: x, y, ch_in, ch_out, k_v, k_h. Counters are 32-bit and advance only on fire. An inner counter wrapping at bound-1 to 0 increments the next outer counter. last_overall = all counters at bound-1.
- Same cycle as fire: mem_re = (k_v==0 && k_h==0) && ch_in!=0; mem_read_addr = ch_out (truncated to address width). Memory read latency is 1 cycle.
- One cycle after fire (registered, captured from the pre-advance counters):
  - mac_valid = 1
  - mac_accumulate_internal = !(k_v==0 && k_h==0)
  - mac_accumulate_with_0 = (ch_in==0 && k_v==0 && k_h==0)
- Write-back: tag = the mac_valid beat with k_v and k_h both at last. MAC_PIPE_DEPTH cycles after that mac_valid: mem_we=1 and mem_write_addr=ch_out of the tag.
- Output: a tag with last ch_in, delayed by the same MAC_PIPE_DEPTH, gives output_valid=1 with output_x/y/ch of that beat. Coordinate registers hold their value when output_valid=0.
- DRAIN keeps the delay lines shifting until the last output has emerged.
- Degenerate KERNEL_SIZE=1: every beat is first and last; mac_accumulate_internal is always 0.

Optional Feature:
CONV_CTRL_PERF_CNT_EN
- Defined: adds port stall_cycles, a 32-bit saturating count of RUN cycles without fire. It clears on start in IDLE and holds in IDLE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. W=H=2, Cin=Cout=2, K=2, depth=4, valids tied high, start pulse -> 64 fires in 64 consecutive cycles. mac_valid trails each fire by 1 cycle. 16 mem_we pulses and 8 output_valid pulses; the last output_valid occurs 5 cycles after the final fire; running falls 1 cycle later.
2. Same config, a_valid toggled every other cycle -> no fire while a_valid=0, counter values frozen, output sequence identical to test 1 (only time-stretched).
3. K=3, ch_in=0 beat (0,0) -> mem_re=0 and mac_accumulate_with_0=1. For ch_in=1 beat (0,0): mem_re=1, mem_read_addr=ch_out, and mac_accumulate_with_0=0 one cycle later.
4. Pulse arst_n_in low mid-RUN -> all outputs 0 immediately, state IDLE. A new start then restarts the layer at x=y=ch=k=0.
5. start pulsed during RUN and DRAIN -> no effect. Pulse start 1 cycle after running drops -> new layer begins.
6. With CONV_CTRL_PERF_CNT_EN, run test 2 -> stall_cycles equals the number of RUN cycles with a_valid=0 (64 for a 50% duty pattern), and holds after IDLE.
